// File: rtl/sdram_arbiter.sv
`timescale 1ns/1ps
// Slot arbiter sharing one SDRAM port between video, DMA and CPU in 16-cycle slots.
// Latency: grant takes effect the cycle after a ph==15 boundary; ack and read data arrive one slot later.
// Backpressure: requesters hold req until their one-cycle ack; forced idle slots pause all traffic for refresh.
module sdram_arbiter #(
    parameter int REFRESH_MAX = 31,
    parameter int CPU_STARVE  = 2
) (
    input  logic        clk_128,
    input  logic        init,
    input  logic        clk_8_en,

    input  logic        vid_req,
    input  logic [23:0] vid_addr,
    output logic        vid_ack,

    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [23:0] dma_addr,
    input  logic [1:0]  dma_ds,
    input  logic [15:0] dma_din,
    output logic        dma_ack,

    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [23:0] cpu_addr,
    input  logic [1:0]  cpu_ds,
    input  logic [15:0] cpu_din,
    output logic        cpu_ack,

    output logic [63:0] rdata,

    output logic        ram_oe,
    output logic        ram_we,
    output logic [23:0] ram_addr,
    output logic [1:0]  ram_ds,
    output logic [15:0] ram_din,
    input  logic [63:0] ram_dout,

    output logic        refresh_slot
);

    // Counter widths sized so the saturation values fit exactly.
    localparam int RW = (REFRESH_MAX > 1) ? $clog2(REFRESH_MAX + 1) : 1;
    localparam int SW = (CPU_STARVE  > 1) ? $clog2(CPU_STARVE  + 1) : 1;
    localparam logic [RW-1:0] REF_MAX_V = RW'(REFRESH_MAX);
    localparam logic [SW-1:0] STARVE_V  = SW'(CPU_STARVE);

    // Slot owner encoding; NONE covers both forced and voluntary idle slots.
    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_VID  = 2'd1;
    localparam logic [1:0] OWN_DMA  = 2'd2;
    localparam logic [1:0] OWN_CPU  = 2'd3;

    logic          clk8_q,   clk8_d;
    logic [3:0]    ph_q,     ph_d;
    logic [RW-1:0] ref_q,    ref_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [1:0]    owner_q,  owner_d;

    logic          ram_oe_q,   ram_oe_d;
    logic          ram_we_q,   ram_we_d;
    logic [23:0]   ram_addr_q, ram_addr_d;
    logic [1:0]    ram_ds_q,   ram_ds_d;
    logic [15:0]   ram_din_q,  ram_din_d;
    logic          refresh_q,  refresh_d;
    logic [63:0]   rdata_q,    rdata_d;
    logic          vid_ack_q,  vid_ack_d;
    logic          dma_ack_q,  dma_ack_d;
    logic          cpu_ack_q,  cpu_ack_d;

    logic          sync_edge;
    logic          boundary;
    logic          forced_idle;
    logic          cpu_starved;
    logic [1:0]    grant;

    // Phase tracking: re-align to mid-slot on each rising clk_8_en, otherwise free-run.
    always_comb begin
        sync_edge = clk_8_en & ~clk8_q;
        clk8_d    = clk_8_en;
        ph_d      = sync_edge ? 4'd9 : (ph_q + 4'd1);
        boundary  = (ph_q == 4'd15);
    end

    // Arbitration: picks next slot owner; forced idle outranks everything, starved CPU outranks DMA.
    always_comb begin
        forced_idle = (ref_q == REF_MAX_V);
        cpu_starved = (starve_q >= STARVE_V);
        grant       = OWN_NONE;
        if (!forced_idle) begin
            if (vid_req)                     grant = OWN_VID;
            else if (cpu_req && cpu_starved) grant = OWN_CPU;
            else if (dma_req)                grant = OWN_DMA;
            else if (cpu_req)                grant = OWN_CPU;
            else                             grant = OWN_NONE;
        end
    end

    // Slot update: at the boundary, retire the closing slot (ack, read capture) and load the new one.
    always_comb begin
        owner_d    = owner_q;
        ref_d      = ref_q;
        starve_d   = starve_q;
        ram_oe_d   = ram_oe_q;
        ram_we_d   = ram_we_q;
        ram_addr_d = ram_addr_q;
        ram_ds_d   = ram_ds_q;
        ram_din_d  = ram_din_q;
        refresh_d  = refresh_q;
        rdata_d    = rdata_q;
        vid_ack_d  = 1'b0;
        dma_ack_d  = 1'b0;
        cpu_ack_d  = 1'b0;

        if (boundary) begin
            // Close the slot that is ending. A held req at this same edge is treated
            // as the requester's next request, so back-to-back service is legal.
            vid_ack_d = (owner_q == OWN_VID);
            dma_ack_d = (owner_q == OWN_DMA);
            cpu_ack_d = (owner_q == OWN_CPU);
            if ((owner_q != OWN_NONE) && ram_oe_q) begin
                rdata_d = ram_dout;
            end

            // Open the next slot.
            owner_d   = grant;
            refresh_d = forced_idle;
            case (grant)
                OWN_VID: begin
                    ram_oe_d   = 1'b1;
                    ram_we_d   = 1'b0;
                    ram_addr_d = vid_addr;
                    ram_ds_d   = 2'b11;
                    ram_din_d  = 16'h0000;
                end
                OWN_DMA: begin
                    ram_oe_d   = ~dma_we;
                    ram_we_d   = dma_we;
                    ram_addr_d = dma_addr;
                    ram_ds_d   = dma_we ? dma_ds  : 2'b11;
                    ram_din_d  = dma_we ? dma_din : 16'h0000;
                end
                OWN_CPU: begin
                    ram_oe_d   = ~cpu_we;
                    ram_we_d   = cpu_we;
                    ram_addr_d = cpu_addr;
                    ram_ds_d   = cpu_we ? cpu_ds  : 2'b11;
                    ram_din_d  = cpu_we ? cpu_din : 16'h0000;
                end
                default: begin
                    ram_oe_d   = 1'b0;
                    ram_we_d   = 1'b0;
                    ram_addr_d = 24'h000000;
                    ram_ds_d   = 2'b00;
                    ram_din_d  = 16'h0000;
                end
            endcase

            // Refresh pacing: count busy slots, any idle slot lets the SDRAM refresh.
            if (grant == OWN_NONE) begin
                ref_d = '0;
            end else if (ref_q != REF_MAX_V) begin
                ref_d = ref_q + RW'(1);
            end

            // CPU fairness: count boundaries the waiting CPU lost.
            if (cpu_req && (grant != OWN_CPU)) begin
                if (starve_q != STARVE_V) begin
                    starve_d = starve_q + SW'(1);
                end
            end else begin
                starve_d = '0;
            end
        end
    end

    // State registers; init aborts any in-flight slot without an ack.
    always_ff @(posedge clk_128 or posedge init) begin
        if (init) begin
            clk8_q     <= 1'b0;
            ph_q       <= 4'd0;
            ref_q      <= '0;
            starve_q   <= '0;
            owner_q    <= OWN_NONE;
            ram_oe_q   <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= 24'h000000;
            ram_ds_q   <= 2'b00;
            ram_din_q  <= 16'h0000;
            refresh_q  <= 1'b0;
            rdata_q    <= 64'h0;
            vid_ack_q  <= 1'b0;
            dma_ack_q  <= 1'b0;
            cpu_ack_q  <= 1'b0;
        end else begin
            clk8_q     <= clk8_d;
            ph_q       <= ph_d;
            ref_q      <= ref_d;
            starve_q   <= starve_d;
            owner_q    <= owner_d;
            ram_oe_q   <= ram_oe_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_ds_q   <= ram_ds_d;
            ram_din_q  <= ram_din_d;
            refresh_q  <= refresh_d;
            rdata_q    <= rdata_d;
            vid_ack_q  <= vid_ack_d;
            dma_ack_q  <= dma_ack_d;
            cpu_ack_q  <= cpu_ack_d;
        end
    end

    assign ram_oe       = ram_oe_q;
    assign ram_we       = ram_we_q;
    assign ram_addr     = ram_addr_q;
    assign ram_ds       = ram_ds_q;
    assign ram_din      = ram_din_q;
    assign refresh_slot = refresh_q;
    assign rdata        = rdata_q;
    assign vid_ack      = vid_ack_q;
    assign dma_ack      = dma_ack_q;
    assign cpu_ack      = cpu_ack_q;

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter REFRESH_MAX, default 31, max consecutive granted slots before a forced idle (refresh) slot.
REQ-002 Parameter CPU_STARVE, default 2, consecutive lost slots after which a pending CPU request outranks DMA.
REQ-003 clk_128  in  1  128 MHz clock; single clock domain.
REQ-004 init  in  1  reset, asynchronous, active-high.
REQ-005 clk_8_en  in  1  8 MHz chipset enable; its rising edge marks mid-slot.
REQ-006 vid_req  in  1 / vid_addr  in  24  video read request, word address.
REQ-007 vid_ack  out  1  one-cycle pulse; read data valid on rdata.
REQ-008 dma_req, dma_we  in  1 / dma_addr  in  24 / dma_ds  in  2 / dma_din  in  16  DMA request.
REQ-009 dma_ack  out  1  one-cycle completion pulse.
REQ-010 cpu_req, cpu_we  in  1 / cpu_addr  in  24 / cpu_ds  in  2 / cpu_din  in  16  CPU request.
REQ-011 cpu_ack  out  1  one-cycle completion pulse.
REQ-012 rdata  out  64  shared read-data return bus.
REQ-013 ram_oe, ram_we  out  1 / ram_addr  out  24 / ram_ds  out  2 / ram_din  out  16  to SDRAM controller.
REQ-014 ram_dout  in  64  burst read data from SDRAM controller.
REQ-015 refresh_slot  out  1  high for the whole of a forced idle slot.

Function
REQ-016 Phase counter ph[3:0]: set to 9 on the cycle after a clk_8_en rising edge is detected, else increments, wrapping 15->0.
REQ-017 Slot boundary = cycle with ph==15; all grant decisions, output updates and acks occur only there.
REQ-018 Grant priority at boundary: forced idle > video > CPU if starved > DMA > CPU > none.
REQ-019 Forced idle: when refresh counter == REFRESH_MAX, no grant; ram_oe=ram_we=0 for the next slot; refresh_slot=1.
REQ-020 Refresh counter: increments per granted slot, clears on any idle slot (forced or no request), saturates at REFRESH_MAX.
REQ-021 Starve counter: increments at each boundary where cpu_req is high and CPU not granted; clears when CPU granted or cpu_req low; saturates at CPU_STARVE.
REQ-022 Granted request drives ram_addr/ram_ds/ram_din/ram_oe/ram_we from the next cycle, held stable for 16 cycles.
REQ-023 Read: ram_oe=1, ram_we=0, ram_ds=2'b11; write: ram_we=1, ram_oe=0, ram_ds=requester ds.
REQ-024 Video requests are always reads; vid_we does not exist.
REQ-025 At the boundary closing a served slot: pulse that requester's ack for exactly one cycle; for reads, rdata<=ram_dout the same edge.
REQ-026 rdata holds its value until the next read completion.
REQ-027 Requesters hold req/addr/ds/din/we stable until ack; req high in the cycle after ack is a new request.
REQ-028 A requester is never granted two consecutive slots while its ack from the prior slot is still pending (ack coincides with the boundary, so back-to-back grants are allowed).
REQ-029 Simultaneous boundary events: ack of slot N and grant of slot N+1 occur on the same edge.
REQ-030 If no clk_8_en edge is seen, ph free-runs; re-sync to 9 on a later edge without emitting spurious acks.
REQ-031 Each ack count equals grant count; no request is granted without a later ack unless init intervenes.

Reset
REQ-032 init asserted: ph=0, all counters 0, ram_oe=ram_we=0, ram_addr=0, ram_ds=0, ram_din=0, all acks 0, rdata=0, refresh_slot=0.
REQ-033 init mid-slot aborts the in-flight access; no ack is ever issued for it.
REQ-034 After init release, first grant occurs at the first ph==15 boundary.

Verification
REQ-035 vid_req+dma_req+cpu_req at one boundary -> video granted; vid_ack one cycle 16 clocks later with rdata==ram_dout.
REQ-036 cpu_req+dma_req held continuously, CPU_STARVE=2 -> grant sequence DMA, DMA, CPU, DMA, DMA, CPU.
REQ-037 cpu write addr=0x012345, ds=2'b01, din=0xBEEF -> ram_we=1, ram_addr=0x012345, ram_ds=2'b01, ram_din=0xBEEF stable 16 cycles; cpu_ack pulses, rdata unchanged.
REQ-038 vid_req held 40 slots, REFRESH_MAX=31 -> 31 grants, one slot with refresh_slot=1 and ram_oe=0, then grants resume.
REQ-039 init pulsed at ph=5 of a DMA read slot -> all outputs zero immediately, no dma_ack; dma_req still high is re-served in a later slot.
REQ-040 No requests for 3 slots -> ram_oe=ram_we=0, no acks, refresh counter 0.
